// File: rtl/proc_controller.sv
// Multi-cycle control unit for the 10-bit shared-bus processor.
// Ports: CLK, RST (sync, active-high), EXEC (button level), DIN (switches)
//   in; TIME (registered timestep), DONE, and the bus/regfile/ALU strobes
//   EXT, ROUT, ROUT_ADDR, RIN, RIN_ADDR, AIN, GIN, GOUT, ALU_OP out.
module proc_controller #(
    parameter int DATA_W = 10,
    parameter int RA_W   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXEC,
    input  logic [DATA_W-1:0] DIN,
    output logic [1:0]        TIME,
    output logic              DONE,
    output logic              EXT,
    output logic              ROUT,
    output logic [RA_W-1:0]   ROUT_ADDR,
    output logic              RIN,
    output logic [RA_W-1:0]   RIN_ADDR,
    output logic              AIN,
    output logic              GIN,
    output logic              GOUT,
    output logic [1:0]        ALU_OP
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_COPY = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_INV  = 3'b100;

    step_t             step;
    logic [DATA_W-1:0] ir;
    logic              exec_q;
    logic              exec_rise;
    logic [2:0]        opcode;
    logic [RA_W-1:0]   rx;
    logic [RA_W-1:0]   ry;
    logic              unused_ir;

    assign exec_rise = EXEC & ~exec_q;
    assign opcode    = ir[DATA_W-1:DATA_W-3];
    assign rx        = ir[2*RA_W-1:RA_W];
    assign ry        = ir[RA_W-1:0];
    assign unused_ir = ^ir[DATA_W-4:2*RA_W];
    assign TIME      = step;

    // exec_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            step   <= T0;
            ir     <= '0;
            exec_q <= 1'b1;
        end else begin
            exec_q <= EXEC;
            case (step)
                T0: begin
                    if (exec_rise) begin
                        ir   <= DIN;
                        step <= T1;
                    end
                end
                T1: begin
                    case (opcode)
                        // LOAD waits here for the data-word press.
                        OP_LOAD: if (exec_rise) step <= T0;
                        OP_ADD, OP_SUB, OP_INV: step <= T2;
                        default: step <= T0;
                    endcase
                end
                T2: step <= T3;
                T3: step <= T0;
            endcase
        end
    end

    always_comb begin
        DONE      = 1'b0;
        EXT       = 1'b0;
        ROUT      = 1'b0;
        ROUT_ADDR = '0;
        RIN       = 1'b0;
        RIN_ADDR  = '0;
        AIN       = 1'b0;
        GIN       = 1'b0;
        GOUT      = 1'b0;
        ALU_OP    = 2'b00;
        case (step)
            T0: ;
            T1: begin
                case (opcode)
                    OP_LOAD: begin
                        EXT = 1'b1;
                        if (exec_rise) begin
                            RIN      = 1'b1;
                            RIN_ADDR = rx;
                            DONE     = 1'b1;
                        end
                    end
                    OP_COPY: begin
                        ROUT      = 1'b1;
                        ROUT_ADDR = ry;
                        RIN       = 1'b1;
                        RIN_ADDR  = rx;
                        DONE      = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_INV: begin
                        ROUT      = 1'b1;
                        ROUT_ADDR = rx;
                        AIN       = 1'b1;
                    end
                    default: DONE = 1'b1;
                endcase
            end
            T2: begin
                ROUT      = 1'b1;
                ROUT_ADDR = ry;
                GIN       = 1'b1;
                case (opcode)
                    OP_SUB:  ALU_OP = 2'b01;
                    OP_INV:  ALU_OP = 2'b10;
                    default: ALU_OP = 2'b00;
                endcase
            end
            T3: begin
                GOUT     = 1'b1;
                RIN      = 1'b1;
                RIN_ADDR = rx;
                DONE     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_controller.sv
// Testbench for proc_controller: directed vector table, hand sequences and
// random stimulus checked against a per-instruction micro-step model.
module tb_proc_controller;

    typedef struct packed {
        logic [1:0] t;
        logic       done;
        logic       ext;
        logic       rout;
        logic [1:0] ra;
        logic       rin;
        logic [1:0] wa;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [1:0] op;
    } ctl_t;

    typedef struct {
        bit         rst;
        bit         ex;
        logic [9:0] din;
        ctl_t       exp;
        string      nm;
    } vec_t;

    typedef struct {
        ctl_t       c;
        bit         lw;
        logic [1:0] rx;
    } plan_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex = 1'b1;
    logic [9:0] din = '0;
    logic [1:0] t_time;
    logic       t_done, t_ext, t_rout, t_rin, t_ain, t_gin, t_gout;
    logic [1:0] t_ra, t_wa, t_op;

    int tests = 0;
    int fails = 0;

    vec_t  tab[$];
    plan_t plan[$];
    bit    prev_ex = 1'b1;

    always #5 clk = ~clk;

    proc_controller dut (
        .CLK(clk), .RST(rst), .EXEC(ex), .DIN(din),
        .TIME(t_time), .DONE(t_done), .EXT(t_ext), .ROUT(t_rout),
        .ROUT_ADDR(t_ra), .RIN(t_rin), .RIN_ADDR(t_wa), .AIN(t_ain),
        .GIN(t_gin), .GOUT(t_gout), .ALU_OP(t_op)
    );

    function automatic ctl_t mk(input logic [1:0] t, input bit dn, input bit e,
                                input bit ro, input logic [1:0] ra, input bit ri,
                                input logic [1:0] wa, input bit a, input bit g,
                                input bit go, input logic [1:0] op);
        ctl_t c;
        c = '{t, dn, e, ro, ra, ri, wa, a, g, go, op};
        return c;
    endfunction

    // Micro-step list for one instruction, from the opcode table.
    task automatic build_plan(input logic [9:0] d);
        logic [2:0] opc;
        logic [1:0] rx, ry;
        plan_t p;
        opc = d[9:7];
        rx = d[3:2];
        ry = d[1:0];
        p.lw = 1'b0;
        p.rx = rx;
        case (opc)
            3'd0: begin
                p.c = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                p.lw = 1'b1;
                plan.push_back(p);
            end
            3'd1: begin
                p.c = mk(1, 1, 0, 1, ry, 1, rx, 0, 0, 0, 0);
                plan.push_back(p);
            end
            3'd2, 3'd3, 3'd4: begin
                p.c = mk(1, 0, 0, 1, rx, 0, 0, 1, 0, 0, 0);
                plan.push_back(p);
                p.c = mk(2, 0, 0, 1, ry, 0, 0, 0, 1, 0, 2'(opc - 3'd2));
                plan.push_back(p);
                p.c = mk(3, 1, 0, 0, 0, 1, rx, 0, 0, 1, 0);
                plan.push_back(p);
            end
            default: begin
                p.c = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                plan.push_back(p);
            end
        endcase
    endtask

    task automatic cmp(input string nm, input ctl_t act, input ctl_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [9:0] d,
                        input bit use_tab, input ctl_t texp, input string nm,
                        input bit chk);
        ctl_t act, mexp;
        bit rise;
        @(negedge clk);
        rst = r;
        ex = e;
        din = d;
        #1;
        act = {t_time, t_done, t_ext, t_rout, t_ra, t_rin, t_wa,
               t_ain, t_gin, t_gout, t_op};
        rise = e & ~prev_ex;
        if (plan.size() == 0) begin
            mexp = '0;
        end else begin
            mexp = plan[0].c;
            if (plan[0].lw && rise) begin
                mexp.rin = 1'b1;
                mexp.wa = plan[0].rx;
                mexp.done = 1'b1;
            end
        end
        if (chk) begin
            cmp({nm, "_model"}, act, mexp);
            if (use_tab) cmp(nm, act, texp);
            tests++;
            if (32'(t_ext) + 32'(t_rout) + 32'(t_gout) > 1) begin
                fails++;
                $display("FAIL %s_onehot: ext=%b rout=%b gout=%b want at most one",
                         nm, t_ext, t_rout, t_gout);
            end
        end
        if (r) begin
            plan.delete();
            prev_ex = 1'b1;
        end else begin
            if (plan.size() == 0) begin
                if (rise) build_plan(d);
            end else if (!plan[0].lw || rise) begin
                void'(plan.pop_front());
            end
            prev_ex = e;
        end
    endtask

    task automatic add(input bit r, input bit e, input logic [9:0] d,
                       input ctl_t c, input string nm);
        vec_t v;
        v = '{r, e, d, c, nm};
        tab.push_back(v);
    endtask

    initial begin
        ctl_t z;
        z = '0;
        // reset with button held, then release and press
        add(1, 1, 0, z, "rst0");
        add(1, 1, 0, z, "rst1");
        add(0, 1, 0, z, "rst_hold0");
        add(0, 1, 0, z, "rst_hold1");
        add(0, 0, 0, z, "rst_rel");
        // LOAD R1 <- 0x155
        add(0, 1, 10'h004, z, "ld_t0");
        add(0, 1, 10'h155, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ld_t1_hold");
        add(0, 0, 10'h155, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ld_t1_low");
        add(0, 1, 10'h155, mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0), "ld_t1_press");
        add(0, 1, 10'h155, z, "ld_done_hold0");
        add(0, 1, 10'h155, z, "ld_done_hold1");
        add(0, 0, 10'h155, z, "ld_rel");
        // ADD R2,R1 (button re-pressed in T2: ignored)
        add(0, 1, 10'h109, z, "add_t0");
        add(0, 0, 0, mk(1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0), "add_t1");
        add(0, 1, 0, mk(2, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), "add_t2");
        add(0, 0, 0, mk(3, 1, 0, 0, 0, 1, 2, 0, 0, 1, 0), "add_t3");
        add(0, 0, 0, z, "add_end");
        // SUB R1,R2
        add(0, 1, 10'h186, z, "sub_t0");
        add(0, 0, 0, mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0), "sub_t1");
        add(0, 0, 0, mk(2, 0, 0, 1, 2, 0, 0, 0, 1, 0, 1), "sub_t2");
        add(0, 0, 0, mk(3, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0), "sub_t3");
        add(0, 0, 0, z, "sub_end");
        // INV R3,R0
        add(0, 1, 10'h20C, z, "inv_t0");
        add(0, 0, 0, mk(1, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0), "inv_t1");
        add(0, 0, 0, mk(2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2), "inv_t2");
        add(0, 0, 0, mk(3, 1, 0, 0, 0, 1, 3, 0, 0, 1, 0), "inv_t3");
        add(0, 0, 0, z, "inv_end");
        // COPY R0 <- R3
        add(0, 1, 10'h083, z, "cpy_t0");
        add(0, 0, 0, mk(1, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0), "cpy_t1");
        add(0, 0, 0, z, "cpy_end");
        // illegal opcode 111
        add(0, 1, 10'h380, z, "ill_t0");
        add(0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_t1");
        add(0, 0, 0, z, "ill_end");
        // reset in T2 of ADD
        add(0, 1, 10'h109, z, "rsta_t0");
        add(0, 0, 0, mk(1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0), "rsta_t1");
        add(1, 0, 0, mk(2, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), "rsta_t2");
        add(0, 0, 0, z, "rsta_after0");
        add(0, 0, 0, z, "rsta_after1");
        // press coinciding with reset is dropped
        add(1, 1, 10'h083, z, "rstx_press");
        add(0, 1, 10'h083, z, "rstx_after");
        add(0, 0, 0, z, "rstx_rel");

        for (int i = 0; i < tab.size(); i++)
            step(tab[i].rst, tab[i].ex, tab[i].din, 1'b1, tab[i].exp,
                 tab[i].nm, i != 0);

        tests++;
        if (dut.ir !== 10'h0) begin
            fails++;
            $display("FAIL ir_after_reset: got %h want 000", dut.ir);
        end

        // reset while LOAD waits for its data press
        step(0, 1, 10'h00C, 0, z, "ldr_t0", 1);
        step(0, 0, 0, 0, z, "ldr_t1", 1);
        step(1, 0, 0, 0, z, "ldr_rst", 1);
        step(0, 1, 0, 0, z, "ldr_after", 1);
        step(0, 0, 0, 0, z, "ldr_rel", 1);
        // long LOAD wait, then data press into R3
        step(0, 1, 10'h00C, 0, z, "ldw_t0", 1);
        for (int i = 0; i < 6; i++)
            step(0, 0, 10'h3FF, 0, z, "ldw_wait", 1);
        step(0, 1, 10'h2AA, 0, z, "ldw_press", 1);
        step(0, 0, 0, 0, z, "ldw_end", 1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 10'($urandom), 0, z, "rand", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
